// File: rtl/caesar_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// caesar_symbol_sequencer
//
// Source stage of the Caesar cipher datapath. Everything runs in the single
// Clk_50MHz domain. The symbol rate is set by a tick enable, not by a derived
// clock. Raw switches are synchronised and debounced, and the key is clamped
// to 0..25. The stage then emits a plaintext/cyphertext symbol stream with a
// one-cycle valid strobe.
//
// Parameters
//   TICK_DIV  clock cycles per symbol advance (>= 2)
//   DEBOUNCE  stable cycles needed to commit a switch change (>= 1)
//   SYM_MAX   last symbol value before wrapping to 0
//
// Ports
//   Clk_50MHz    in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   sw_key[4:0]  in   raw key switches (asynchronous)
//   sw_mode      in   raw mode switch (0 = encrypt, 1 = decrypt)
//   hold         in   raw pause switch (1 freezes the symbol)
//   symbol[5:0]  out  current symbol, 0..SYM_MAX
//   key[4:0]     out  committed key, 0..25
//   mode         out  committed mode
//   sym_valid    out  strobe: symbol/key/mode updated this cycle
//   key_clamped  out  committed raw key was above 25
// ---------------------------------------------------------------------------
module caesar_symbol_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int DEBOUNCE = 500000,
    parameter int SYM_MAX  = 25
) (
    input  logic       Clk_50MHz,
    input  logic       rst,
    input  logic [4:0] sw_key,
    input  logic       sw_mode,
    input  logic       hold,
    output logic [5:0] symbol,
    output logic [4:0] key,
    output logic       mode,
    output logic       sym_valid,
    output logic       key_clamped
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE);
    localparam logic [5:0]        SYM_LAST  = 6'(SYM_MAX);
    localparam logic [4:0]        KEY_MAX   = 5'd25;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_RELOAD = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous switches
    // -----------------------------------------------------------------------
    logic [4:0] r_key_s1;
    logic [4:0] r_key_s2;
    logic       r_mode_s1;
    logic       r_mode_s2;
    logic       r_hold_s1;
    logic       r_hold_s2;

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every flop samples the pre-edge value of its inputs.
    // NOTE: the synchroniser flops are reset as well. This keeps the debounce
    // candidate at a known 0 right after reset, and no spurious change is
    // detected.
    always_ff @(posedge Clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_key_s1  <= '0;
            r_key_s2  <= '0;
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
            r_hold_s1 <= 1'b0;
            r_hold_s2 <= 1'b0;
        end else begin
            r_key_s1  <= sw_key;
            r_key_s2  <= r_key_s1;
            r_mode_s1 <= sw_mode;
            r_mode_s2 <= r_mode_s1;
            r_hold_s1 <= hold;
            r_hold_s2 <= r_hold_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce
    //
    // The counter value in a cycle describes the candidate present in that
    // same cycle. It is 0 when the candidate matches the committed value, 1
    // in the first cycle of a new candidate, and +1 for each further stable
    // cycle. The candidate for the next cycle is already visible in the first
    // synchroniser stage. The next counter value is therefore computed from
    // that stage, so a change restarts the count in the cycle where it
    // appears. The commit fires at the end of the cycle where the count
    // equals DEBOUNCE.
    // -----------------------------------------------------------------------
    logic [5:0]      w_cand;
    logic [5:0]      w_cand_next;
    logic [5:0]      w_committed_next;
    logic            w_commit;
    logic [5:0]      r_committed;
    logic [DB_W-1:0] r_db_cnt;

    assign w_cand      = {r_mode_s2, r_key_s2};
    assign w_cand_next = {r_mode_s1, r_key_s1};

    // The count can only be non-zero while the candidate differs from the
    // committed value. The explicit compare keeps the commit safe even so.
    assign w_commit         = (r_db_cnt == DB_LAST) && (w_cand != r_committed);
    assign w_committed_next = w_commit ? w_cand : r_committed;

    always_ff @(posedge Clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_committed <= '0;
            r_db_cnt    <= '0;
        end else begin
            r_committed <= w_committed_next;
            if (w_cand_next == w_committed_next) begin
                r_db_cnt <= '0;
            end else if (w_cand_next != w_cand) begin
                r_db_cnt <= DB_W'(1);
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Key clamp. The displayed key saturates at 25. The flag follows the
    // committed raw value one cycle after the commit, which is the reload
    // cycle where the new key appears.
    logic [4:0] w_key_sat;
    logic       r_key_clamped;

    assign w_key_sat = (r_committed[4:0] > KEY_MAX) ? KEY_MAX : r_committed[4:0];

    always_ff @(posedge Clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_key_clamped <= 1'b0;
        end else begin
            r_key_clamped <= (r_committed[4:0] > KEY_MAX);
        end
    end

    // -----------------------------------------------------------------------
    // Symbol-rate tick. The counter is free-running and ignores hold. It is
    // realigned only on a reload, so the first advance after a key/mode
    // change comes a full period after the reload strobe.
    // -----------------------------------------------------------------------
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    state_t            r_state;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge Clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (r_state == S_RELOAD || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -----------------------------------------------------------------------
    logic [5:0] r_symbol;
    logic [4:0] r_key;
    logic       r_mode;
    logic       r_sym_valid;
    logic [5:0] w_sym_inc;

    assign w_sym_inc = (r_symbol >= SYM_LAST) ? 6'd0 : (r_symbol + 6'd1);

    always_ff @(posedge Clk_50MHz or negedge rst) begin
        if (!rst) begin
            r_state     <= S_INIT;
            r_symbol    <= '0;
            r_key       <= '0;
            r_mode      <= 1'b0;
            r_sym_valid <= 1'b0;
        end else begin
            r_sym_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    // Announce the post-reset state once. No commit can be
                    // pending here: the debounce needs at least three cycles
                    // after reset to reach one.
                    r_symbol    <= '0;
                    r_key       <= '0;
                    r_mode      <= 1'b0;
                    r_sym_valid <= 1'b1;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    // A commit outranks a tick in the same cycle. The tick
                    // is dropped because the reload restarts the sequence.
                    if (w_commit) begin
                        r_state <= S_RELOAD;
                    end else if (w_tick && !r_hold_s2) begin
                        r_symbol    <= w_sym_inc;
                        r_sym_valid <= 1'b1;
                    end
                end
                S_RELOAD: begin
                    r_symbol    <= '0;
                    r_key       <= w_key_sat;
                    r_mode      <= r_committed[5];
                    r_sym_valid <= 1'b1;
                    r_state     <= S_RUN;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign symbol      = r_symbol;
    assign key         = r_key;
    assign mode        = r_mode;
    assign sym_valid   = r_sym_valid;
    assign key_clamped = r_key_clamped;

endmodule

// File: tb/tb_caesar_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// tb_caesar_symbol_sequencer
//
// Bench for caesar_symbol_sequencer with TICK_DIV=4 and DEBOUNCE=3.
//
// The main process drives the switches on falling edges. It pushes each
// expected sym_valid event onto a scoreboard queue, tagged with the exact
// cycle number (rising edges since reset release) when the event must appear.
// A monitor samples on every falling edge:
//   - each strobe is popped and compared against the next queued event;
//   - each cycle without a strobe must leave the outputs unchanged.
// A table of switch vectors covers commit latency and key clamping. The
// hold, bounce, commit/tick collision and mid-run reset cases are written
// out by hand.
// ---------------------------------------------------------------------------
module tb_caesar_symbol_sequencer;

    localparam int TICK_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int SYM_MAX  = 25;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sw_key;
    logic       sw_mode;
    logic       hold;
    logic [5:0] symbol;
    logic [4:0] key;
    logic       mode;
    logic       sym_valid;
    logic       key_clamped;

    caesar_symbol_sequencer #(
        .TICK_DIV (TICK_DIV),
        .DEBOUNCE (DEBOUNCE),
        .SYM_MAX  (SYM_MAX)
    ) dut (
        .Clk_50MHz   (clk),
        .rst         (rst),
        .sw_key      (sw_key),
        .sw_mode     (sw_mode),
        .hold        (hold),
        .symbol      (symbol),
        .key         (key),
        .mode        (mode),
        .sym_valid   (sym_valid),
        .key_clamped (key_clamped)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        int         cyc;
        logic [5:0] sym;
        logic [4:0] key;
        logic       mode;
        logic       clamp;
    } exp_t;

    typedef struct {
        logic [4:0] sw_key;
        logic       sw_mode;
        logic [4:0] exp_key;
        logic       exp_clamp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d, t=%0t)", name, act, req, cyc, $time);
        end
    endtask

    task automatic push(input int c, input int s, input int k, input logic m, input logic cl);
        exp_t e;
        e.cyc   = c;
        e.sym   = 6'(s);
        e.key   = 5'(k);
        e.mode  = m;
        e.clamp = cl;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard monitor.
    initial begin : monitor
        logic [12:0] prev;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = '0;
            end else begin
                if (sym_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_valid: got sym_valid=1 symbol=%0d key=%0d mode=%0d, required no strobe (cycle %0d)",
                                 symbol, key, mode, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("valid_cycle", cyc, e.cyc);
                        check("symbol", symbol, e.sym);
                        check("key", key, e.key);
                        check("mode", mode, e.mode);
                        check("key_clamped", key_clamped, e.clamp);
                    end
                    check("symbol_in_range", symbol <= 6'(SYM_MAX), 1);
                end else begin
                    check("outputs_stable_without_valid", {key_clamped, mode, key, symbol}, prev);
                end
                prev = {key_clamped, mode, key, symbol};
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int r;

        vecs[0] = '{5'd5,  1'b0, 5'd5,  1'b0};
        vecs[1] = '{5'd30, 1'b0, 5'd25, 1'b1};
        vecs[2] = '{5'd3,  1'b0, 5'd3,  1'b0};
        vecs[3] = '{5'd26, 1'b1, 5'd25, 1'b1};
        vecs[4] = '{5'd25, 1'b1, 5'd25, 1'b0};
        vecs[5] = '{5'd31, 1'b0, 5'd25, 1'b1};
        vecs[6] = '{5'd0,  1'b0, 5'd0,  1'b0};
        vecs[7] = '{5'd12, 1'b0, 5'd12, 1'b0};

        rst     = 1'b1;
        sw_key  = '0;
        sw_mode = 1'b0;
        hold    = 1'b0;
        #1 rst  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_symbol", symbol, 0);
        check("rst_key", key, 0);
        check("rst_mode", mode, 0);
        check("rst_sym_valid", sym_valid, 0);
        check("rst_key_clamped", key_clamped, 0);

        // Run from reset. INIT strobes at cycle 1, and ticks fall on multiples
        // of 4. Symbol 7 appears at cycle 28. Hold then suppresses the ticks
        // at 32, 36 and 40. After release, symbol 8 comes at 44 and the
        // sequence wraps 25 -> 0 at cycle 116.
        push(1, 0, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) push(4 * k, k, 0, 1'b0, 1'b0);
        for (int k = 8; k <= 25; k++) push(4 * k + 12, k, 0, 1'b0, 1'b0);
        push(116, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;

        wait_cyc(28);
        hold = 1'b1;
        wait_cyc(40);
        check("hold_freezes_symbol", symbol, 7);
        hold = 1'b0;
        wait_cyc(116);
        hold = 1'b1;

        // Table of switch vectors, applied with hold=1 so only the reload
        // strobe appears. The commit lands 5 cycles after the switch change
        // and the reload output one cycle later. A single advance is then
        // let through 4 cycles after the reload.
        n = 120;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(n);
            sw_key  = vecs[i].sw_key;
            sw_mode = vecs[i].sw_mode;
            push(n + 6, 0, vecs[i].exp_key, vecs[i].sw_mode, vecs[i].exp_clamp);
            wait_cyc(n + 6);
            hold = 1'b0;
            push(n + 10, 1, vecs[i].exp_key, vecs[i].sw_mode, vecs[i].exp_clamp);
            wait_cyc(n + 10);
            hold = 1'b1;
            n = n + 12;
        end
        r = n - 6;

        // Bouncing key bit: the value changes every 2 cycles, which never
        // reaches the 3-cycle debounce count.
        for (int j = 0; j < 10; j++) begin
            wait_cyc(n + 2 * j);
            sw_key = sw_key ^ 5'd1;
        end
        wait_cyc(n + 30);
        check("bounce_key_unchanged", key, 12);
        check("bounce_clamp_unchanged", key_clamped, 0);

        // Mode commit aligned with a tick. Ticks fall on r + 4m, and the
        // commit falls on r + 48. The tick is dropped, and the reload
        // strobes alone one cycle later.
        wait_cyc(r + 36);
        hold = 1'b0;
        push(r + 40, 2, 12, 1'b0, 1'b0);
        push(r + 44, 3, 12, 1'b0, 1'b0);
        push(r + 49, 0, 12, 1'b1, 1'b0);
        push(r + 53, 1, 12, 1'b1, 1'b0);
        wait_cyc(r + 43);
        sw_mode = 1'b1;
        wait_cyc(r + 55);
        check("queue_drained_before_reset", exp_q.size(), 0);

        // Asynchronous reset in the middle of a cycle clears the outputs at once.
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_symbol", symbol, 0);
        check("midrst_key", key, 0);
        check("midrst_mode", mode, 0);
        check("midrst_sym_valid", sym_valid, 0);
        check("midrst_key_clamped", key_clamped, 0);

        // After release: INIT reports key 0 although the switches read
        // {mode=1, key=12}. The fresh commit then reloads at cycle 6.
        hold = 1'b1;
        push(1, 0, 0, 1'b0, 1'b0);
        push(6, 0, 12, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_cyc(14);
        check("queue_drained_at_end", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/caesar_symbol_sequencer.md
Name: caesar_symbol_sequencer

Overview:
Single-clock source stage for the Caesar cipher datapath. It replaces the derived-1Hz-clock plaintext counter with a 50 MHz design that uses a tick enable. It synchronises and debounces the key/mode switches and clamps the key to 0..25. It produces the plaintext symbol stream with a one-cycle valid strobe. Outputs drive the Caesar encrypt/decrypt stage and the binary-to-BCD display converters directly.

Parameters:
TICK_DIV, 50000000, clock cycles per symbol advance (1 Hz at 50 MHz); must be >= 2.
DEBOUNCE, 500000, consecutive stable cycles required to commit a switch change (10 ms); must be >= 1.
SYM_MAX, 25, last symbol value before wrap to 0.

Ports:
Clk_50MHz  input  1  system clock, all logic on the rising edge.
rst  input  1  asynchronous active-low reset.
sw_key  input  5  raw key switches, asynchronous, bit 0 = LSB.
sw_mode  input  1  raw mode switch, asynchronous: 0 = encrypt, 1 = decrypt.
hold  input  1  raw pause switch, asynchronous: 1 freezes the symbol.
symbol  output  6  current plaintext (encrypt) or cyphertext (decrypt) symbol, 0..SYM_MAX.
key  output  5  committed key, 0..25.
mode  output  1  committed mode.
sym_valid  output  1  one-cycle strobe: symbol/key/mode were updated this cycle.
key_clamped  output  1  high while the committed raw key is greater than 25.

Behaviour:
- Reset, asynchronous with rst=0: symbol=0, key=0, mode=0, sym_valid=0, key_clamped=0. All synchroniser, debounce and tick counters = 0. FSM = S_INIT.
- Synchronisers: each of sw_key, sw_mode and hold passes through a 2-flop synchroniser, reset to 0. The cand vector is {sync mode, sync key}, 6 bits.
- Debounce:
  - When cand equals the committed raw value, the debounce counter is 0.
  - When cand differs, the counter increments each cycle.
  - Any cycle in which cand changes resets the counter to 1.
  - When the counter reaches DEBOUNCE, a commit occurs: the committed raw value becomes cand and the counter becomes 0.
- Key clamp: key = min(committed raw key, 25). key_clamped = 1 when the raw key is in 26..31.
- Tick: a free-running counter runs 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1. It runs regardless of hold.
- FSM states and transitions:
  - S_INIT: lasts 1 cycle after reset release. Asserts sym_valid with symbol=0, then goes to S_RUN.
  - S_RUN, on commit: go to S_RELOAD.
  - S_RUN, on tick with sync hold=0: symbol advances with wrap SYM_MAX->0, and sym_valid=1.
  - S_RUN, on tick with sync hold=1: tick is discarded, with no advance and no valid.
  - S_RELOAD: lasts 1 cycle. Sets symbol=0 and loads the new key/mode, asserts sym_valid, clears the tick counter to 0, then returns to S_RUN.
- Simultaneous commit and tick in S_RUN: commit wins, the tick is dropped and the sequence continues via S_RELOAD.
- Latency and registering:
  - All outputs are registered.
  - sym_valid is high in the same cycle the new symbol/key/mode first appear.
  - Commit to output: 1 cycle (S_RELOAD). Raw switch edge to commit: 2 + DEBOUNCE cycles.
- Width rule: symbol never exceeds SYM_MAX. key, mode and symbol change only in cycles where sym_valid=1, except during reset.
- Reset mid-operation: all state is cleared immediately. The next sequence starts at S_INIT with key=0 until a fresh commit occurs.

Test Plan:
1. TICK_DIV=4, DEBOUNCE=3, switches at 0. Release reset -> sym_valid pulses with symbol=0 one cycle after release, then a pulse every 4 cycles with symbol 1,2,...,25,0 (wrap checked).
2. Set sw_key=5 and hold it -> after 2+3 cycles a commit occurs. Next cycle: key=5, symbol=0, sym_valid=1. Next tick 4 cycles later gives symbol=1.
3. Toggle sw_key bit0 every 2 cycles for 20 cycles -> no commit, key unchanged, no extra sym_valid.
4. Set sw_key=30 -> after the commit, key=25 and key_clamped=1. Then sw_key=3 -> key=3 and key_clamped=0.
5. Assert hold=1 at symbol=7 for 12 cycles -> symbol stays 7 with no sym_valid. Release hold -> the next tick gives symbol=8.
6. Align a commit of sw_mode=1 with a tick cycle -> symbol=0, mode=1, with a single sym_valid. Assert rst=0 mid-run -> all outputs 0 immediately, in the same cycle.
